// File: rtl/spi_4094_master.sv
// Serial initiator for a 4094 shift-register chain: shifts a word out MSB-first,
// pulses the latch strobe, and captures the chain's serial return as readback.
//
// state      | meaning
// S_IDLE     | waiting for start
// S_SHIFT_LO | sclk low, sdata set up for the current bit
// S_SHIFT_HI | sclk high, sdata held past the rising edge
// S_STROBE   | strobe high, chain outputs latching
// S_DONE     | one-cycle completion, accepts start like S_IDLE
module spi_4094_master #(
  parameter int NUM_BITS      = 24,
  parameter int CLK_DIV       = 2,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_BITS-1:0] din,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] dout,
  output logic                sclk,
  output logic                sdata,
  output logic                strobe,
  input  logic                miso
);

  localparam int CNT_MAX = (CLK_DIV > STROBE_CYCLES) ? CLK_DIV : STROBE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = $clog2(NUM_BITS) + 1;

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_LO, S_SHIFT_HI, S_STROBE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [NUM_BITS-1:0] tx_q, tx_d;
  logic [NUM_BITS-1:0] rx_q, rx_d;
  logic [NUM_BITS-1:0] dout_q, dout_d;
  logic                sclk_q, sclk_d;
  logic                sdata_q, sdata_d;
  logic                strobe_q, strobe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      dout_q   <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      dout_q   <= dout_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    dout_d   = dout_q;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;
    strobe_d = strobe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          tx_d    = din;
          sdata_d = din[NUM_BITS-1];
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          bit_d   = BIT_LOAD;
          cnt_d   = DIV_LOAD;
          state_d = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (cnt_q == '0) begin
          // miso still shows the chain's last bit; the rising edge below shifts it out
          rx_d    = (rx_q << 1) | NUM_BITS'(miso);
          sclk_d  = 1'b1;
          cnt_d   = DIV_LOAD;
          state_d = S_SHIFT_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SHIFT_HI: begin
        if (cnt_q == '0) begin
          sclk_d = 1'b0;
          if (bit_q != '0) begin
            tx_d    = tx_q << 1;
            sdata_d = tx_d[NUM_BITS-1];
            bit_d   = bit_q - 1'b1;
            cnt_d   = DIV_LOAD;
            state_d = S_SHIFT_LO;
          end else begin
            strobe_d = 1'b1;
            sdata_d  = 1'b0;
            cnt_d    = STB_LOAD;
            state_d  = S_STROBE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          strobe_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          dout_d   = rx_q;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign dout   = dout_q;
  assign sclk   = sclk_q;
  assign sdata  = sdata_q;
  assign strobe = strobe_q;

endmodule

// File: tb/tb_spi_4094_master.sv
// Bench for spi_4094_master: a 24-bit 4094 chain hangs off the main instance and a
// timeline model predicts every output cycle by cycle; a small 8-bit instance is also exercised.
module tb_spi_4094_master;
  localparam int N   = 24;
  localparam int D   = 2;
  localparam int S   = 2;
  localparam int LEN = N * 2 * D + S;

  logic         clk = 1'b0, reset = 1'b1, start = 1'b0, miso;
  logic [N-1:0] din = '0, dout;
  logic         busy, done, sclk, sdata, strobe;
  logic         start8 = 1'b0;
  logic [7:0]   din8 = '0, dout8;
  logic         busy8, done8, sclk8, sdata8, strobe8;

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_4094_master #(.NUM_BITS(N), .CLK_DIV(D), .STROBE_CYCLES(S)) u_dut (
    .clk(clk), .reset(reset), .start(start), .din(din), .busy(busy), .done(done),
    .dout(dout), .sclk(sclk), .sdata(sdata), .strobe(strobe), .miso(miso));

  spi_4094_master #(.NUM_BITS(8), .CLK_DIV(1), .STROBE_CYCLES(1)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .din(din8), .busy(busy8), .done(done8),
    .dout(dout8), .sclk(sclk8), .sdata(sdata8), .strobe(strobe8), .miso(1'b1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // 4094 chain: shifts on sclk rise, outputs follow the shift register when strobe falls
  logic [N-1:0] chain_sr, chain_lat;
  int rises = 0, stb_rises = 0;
  assign miso = chain_sr[N-1];
  always @(posedge sclk) if (chk_en) begin
    chain_sr = {chain_sr[N-2:0], sdata};
    rises++;
  end
  always @(posedge strobe) if (chk_en) stb_rises++;
  always @(negedge strobe) if (chk_en) chain_lat = chain_sr;

  int busy_cyc = 0, stb_cyc = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (strobe) stb_cyc++;
    if (done) done_cnt++;
  end

  // Timeline model: m_k counts cycles since the accepting edge
  bit           m_active = 1'b0, m_done = 1'b0;
  int           m_k = 0;
  logic [N-1:0] m_word = '0, m_rb = '0, m_chain = '0, m_lat = '0, m_dout = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      if (m_active) begin
        int n;
        n = (m_k < D) ? 0 : (m_k - D) / (2 * D) + 1;
        if (n >= N) m_chain = m_word;
        else if (n > 0) m_chain = (m_chain << n) | (m_word >> (N - n));
      end
      m_active = 1'b0;
      m_done   = 1'b0;
      m_dout   = '0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_k++;
        if (m_k == LEN) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_dout   = m_rb;
          m_chain  = m_word;
          m_lat    = m_word;
        end
      end else if (start) begin
        m_active = 1'b1;
        m_k      = 0;
        m_word   = din;
        m_rb     = m_chain;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    logic e_sclk, e_sdata, e_strobe;
    e_sclk = 1'b0; e_sdata = 1'b0; e_strobe = 1'b0;
    if (m_active) begin
      if (m_k < N * 2 * D) begin
        e_sclk  = (m_k % (2 * D)) >= D;
        e_sdata = m_word[N - 1 - m_k / (2 * D)];
      end else begin
        e_strobe = 1'b1;
      end
    end
    check("busy",   32'(busy),      32'(m_active));
    check("done",   32'(done),      32'(m_done));
    check("dout",   32'(dout),      32'(m_dout));
    check("sclk",   32'(sclk),      32'(e_sclk));
    check("sdata",  32'(sdata),     32'(e_sdata));
    check("strobe", 32'(strobe),    32'(e_strobe));
    check("latch",  32'(chain_lat), 32'(m_lat));
  end

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!done && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: got no done expected done within 400 cycles", tag);
    end
  endtask

  task automatic send(input logic [N-1:0] w, input string tag);
    @(negedge clk);
    start = 1'b1;
    din   = w;
    @(negedge clk);
    start = 1'b0;
    din   = N'($urandom);
    wait_done(tag);
  endtask

  // 8-bit instance observers
  logic [7:0] rx8 = '0;
  int rise_cyc8[8];
  int r8 = 0, busy8_cyc = 0, sdata8_cyc = 0, done8_cnt = 0;
  always @(posedge sclk8) if (chk_en) begin
    rx8 = {rx8[6:0], sdata8};
    if (r8 < 8) rise_cyc8[r8] = cyc;
    r8++;
  end
  always @(negedge clk) begin
    if (busy8) busy8_cyc++;
    if (sdata8) sdata8_cyc++;
    if (done8) done8_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] pwr, w3, w4, w5, w6, w7, last, e_rb;
    int b0, s0, d0, r0, sr0, c;
    chain_sr  = N'($urandom);
    chain_lat = N'($urandom);
    m_chain   = chain_sr;
    m_lat     = chain_lat;
    pwr       = chain_sr;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // directed word; first readback is the chain's power-up contents
    b0 = busy_cyc; s0 = stb_cyc; d0 = done_cnt; r0 = rises;
    send(24'hA5C30F, "t1");
    check("t1_dout_powerup", 32'(dout), 32'(pwr));
    @(negedge clk);
    check("t1_busy_cycles", 32'(busy_cyc - b0), 32'd98);
    check("t1_strobe_cycles", 32'(stb_cyc - s0), 32'd2);
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t1_sclk_rises", 32'(rises - r0), 32'd24);
    check("t1_shifted", 32'(chain_sr), 32'h00A5C30F);

    send(24'h123456, "t2a");
    send(24'hABCDEF, "t2b");
    check("t2_readback", 32'(dout), 32'h00123456);
    check("t2_latched", 32'(chain_lat), 32'h00ABCDEF);

    // start pulses and din changes during busy must be ignored
    w3 = 24'h3C96E1;
    @(negedge clk); start = 1'b1; din = w3;
    @(negedge clk); start = 1'b0;
    for (int bc = 2; bc <= 45; bc++) begin
      @(negedge clk);
      if (bc == 5 || bc == 40) begin
        start = 1'b1;
        din   = N'($urandom);
      end else start = 1'b0;
    end
    start = 1'b0;
    wait_done("t3");
    check("t3_shifted", 32'(chain_sr), 32'(w3));
    check("t3_latched", 32'(chain_lat), 32'(w3));

    // reset right after the 10th rising sclk
    w4 = N'($urandom);
    sr0 = stb_rises;
    @(negedge clk); start = 1'b1; din = w4;
    @(negedge clk); start = 1'b0;
    r0 = rises; c = 0;
    while (rises - r0 < 10 && c < 200) begin
      @(posedge clk); #1; c++;
    end
    check("t4_reached_10_rises", 32'(rises - r0), 32'd10);
    reset = 1'b1;
    #1;
    check("t4_rst_busy",   32'(busy),   32'd0);
    check("t4_rst_done",   32'(done),   32'd0);
    check("t4_rst_dout",   32'(dout),   32'd0);
    check("t4_rst_sclk",   32'(sclk),   32'd0);
    check("t4_rst_sdata",  32'(sdata),  32'd0);
    check("t4_rst_strobe", 32'(strobe), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("t4_no_strobe", 32'(stb_rises - sr0), 32'd0);
    check("t4_latch_kept", 32'(chain_lat), 32'(w3));
    w5 = N'($urandom);
    e_rb = (w3 << 10) | (w4 >> 14);
    send(w5, "t4_after");
    check("t4_partial_readback", 32'(dout), 32'(e_rb));
    check("t4_latched", 32'(chain_lat), 32'(w5));

    // start held through the done cycle: back-to-back transfers
    w6 = N'($urandom);
    w7 = N'($urandom);
    @(negedge clk); start = 1'b1; din = w6;
    @(negedge clk); din = w7;
    wait_done("t5a");
    check("t5_first_readback", 32'(dout), 32'(w5));
    @(negedge clk); start = 1'b0;
    check("t5_restarted", 32'(busy), 32'd1);
    check("t5_done_cleared", 32'(done), 32'd0);
    wait_done("t5b");
    check("t5_second_readback", 32'(dout), 32'(w6));
    check("t5_shifted", 32'(chain_sr), 32'(w7));

    // random words with random gaps
    last = w7;
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] w;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      w = N'($urandom);
      send(w, "rand");
      check("rand_readback", 32'(dout), 32'(last));
      last = w;
    end

    // 8-bit, CLK_DIV=1, STROBE_CYCLES=1
    b0 = busy8_cyc; s0 = sdata8_cyc; d0 = done8_cnt;
    @(negedge clk); start8 = 1'b1; din8 = 8'h01;
    @(negedge clk); start8 = 1'b0; din8 = 8'hFE;
    c = 0;
    while (!done8 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("t6_done_seen", 32'(done8), 32'd1);
    check("t6_readback", 32'(dout8), 32'h000000FF);
    @(negedge clk);
    check("t6_busy_cycles", 32'(busy8_cyc - b0), 32'd17);
    check("t6_sdata_high_cycles", 32'(sdata8_cyc - s0), 32'd2);
    check("t6_done_pulses", 32'(done8_cnt - d0), 32'd1);
    check("t6_rises", 32'(r8), 32'd8);
    check("t6_shifted", 32'(rx8), 32'h00000001);
    for (int i = 1; i < 8; i++)
      check("t6_sclk_period", 32'(rise_cyc8[i] - rise_cyc8[i-1]), 32'd2);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
